cond_exec_unit: RTL and testbench
=================================

// Module: cond_exec_unit
// PURPOSE
//  Conditional-execution stage that sits directly downstream of the main instruction decoder.
//  - Holds the architectural NZCV flags register.
//  - Evaluates the instruction's 4-bit condition field against the current flags.
//  - Qualifies the decoder's raw write/branch intents (PCS, RegW, MemW, NoWrite, FlagW)
//    into the committed strobes used by the datapath and PC logic.
//  - Stall-aware through en, so it drops into single-cycle and stalled datapaths unchanged.
// PARAMETERS
//  FLAG_RST  4'b0000  value loaded into Flags[3:0] (N,Z,C,V) on reset
// PORTS
//  clk        in   1  system clock, rising edge
//  reset      in   1  synchronous, active-high reset
//  en         in   1  stage enable; 0 = stall (no state change, no strobes)
//  Cond       in   4  instruction condition field Instr[31:28]
//  ALUFlags   in   4  {N,Z,C,V} from the ALU for the current instruction
//  FlagW      in   2  decoder flag-write request: [1]=N,Z  [0]=C,V
//  PCS        in   1  decoder: instruction writes PC (branch or Rd=R15)
//  RegW       in   1  decoder: register-file write request
//  MemW       in   1  decoder: data-memory write request
//  NoWrite    in   1  decoder: compare-class op (CMP/CMN/TST/TEQ), suppress Rd write
//  PCSrc      out  1  committed PC redirect
//  RegWrite   out  1  committed register-file write enable
//  MemWrite   out  1  committed data-memory write enable
//  CondEx     out  1  condition passed for the current instruction
//  Flags      out  4  current registered {N,Z,C,V}
// BEHAVIOUR
//  Reset
//  - reset=1 at a rising edge: Flags <= FLAG_RST.
//  - While reset=1, PCSrc, RegWrite and MemWrite are forced to 0, regardless of other inputs.
//  Condition evaluation
//  - Combinational, zero latency.
//  - Always uses the registered Flags, never the same-cycle ALUFlags.
//  - Table:
//      0000 EQ Z      0001 NE ~Z     0010 CS C          0011 CC ~C
//      0100 MI N      0101 PL ~N     0110 VS V          0111 VC ~V
//      1000 HI C&~Z   1001 LS ~C|Z   1010 GE N==V       1011 LT N!=V
//      1100 GT ~Z&(N==V)             1101 LE Z|(N!=V)   1110 AL 1
//      1111 reserved, CondEx=0
//  Strobes (combinational; g = CondEx & en & ~reset)
//  - PCSrc    = PCS & g
//  - RegWrite = RegW & ~NoWrite & g
//  - MemWrite = MemW & g
//  Flag update (rising edge, reset has priority)
//  - if g & FlagW[1]: Flags[3:2] <= ALUFlags[3:2]
//  - if g & FlagW[0]: Flags[1:0] <= ALUFlags[1:0]
//  - Each half is independent; a half whose FlagW bit is 0 holds its value.
//  - A failed condition updates no flags, even when FlagW=11.
//  - New flag values are visible to the next instruction: 1-cycle latency.
//  Stall and reset corner cases
//  - en=0: all strobes 0, Flags hold; CondEx is still driven from the held Flags.
//  - reset during a stall: reset wins.
//  - reset asserted mid-sequence: the next cycle starts from FLAG_RST.
// TESTING
//  1. reset=1 for 1 edge -> Flags=0000; PCSrc=RegWrite=MemWrite=0 while reset high.
//  2. Cond=1110, FlagW=11, ALUFlags=0100, RegW=1, NoWrite=1 -> RegWrite=0; next cycle Flags=0100;
//     then Cond=0000, PCS=1 -> PCSrc=1, CondEx=1.
//  3. Flags=0100; Cond=1110, FlagW=10, ALUFlags=1011 -> Flags=1000 (C,V held at 00).
//  4. Flags=0000; Cond=0000, RegW=1, MemW=1, FlagW=11, ALUFlags=1111 -> CondEx=0,
//     RegWrite=0, MemWrite=0; Flags stays 0000.
//  5. Flags=1001 (N=1,V=1): Cond=1010 -> CondEx=1; Cond=1011 -> 0; Cond=1100 -> 1;
//     Cond=1111 -> 0.
//  6. en=0, Cond=1110, RegW=1, FlagW=11, ALUFlags=0110 -> RegWrite=0, Flags unchanged;
//     en=1 next cycle -> RegWrite=1, Flags=0110.

Source files
------------

// File: rtl/cond_exec_unit.sv
// Conditional-execution stage: holds the NZCV flags, evaluates the condition field
// and qualifies the decoder's write/branch intents into committed strobes.
module cond_exec_unit #(
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags
);

    logic n, z, c, v;
    logic go;

    assign {n, z, c, v} = Flags;

    // Condition is always judged against the registered flags, never ALUFlags.
    always_comb begin
        CondEx = 1'b0;
        unique case (Cond)
            4'b0000: CondEx = z;
            4'b0001: CondEx = ~z;
            4'b0010: CondEx = c;
            4'b0011: CondEx = ~c;
            4'b0100: CondEx = n;
            4'b0101: CondEx = ~n;
            4'b0110: CondEx = v;
            4'b0111: CondEx = ~v;
            4'b1000: CondEx = c & ~z;
            4'b1001: CondEx = ~c | z;
            4'b1010: CondEx = (n == v);
            4'b1011: CondEx = (n != v);
            4'b1100: CondEx = ~z & (n == v);
            4'b1101: CondEx = z | (n != v);
            4'b1110: CondEx = 1'b1;
            4'b1111: CondEx = 1'b0;
        endcase
    end

    assign go       = CondEx & en & ~reset;
    assign PCSrc    = PCS & go;
    assign RegWrite = RegW & ~NoWrite & go;
    assign MemWrite = MemW & go;

    always_ff @(posedge clk) begin
        if (reset) begin
            Flags <= FLAG_RST;
        end else begin
            if (go && FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
            if (go && FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
        end
    end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Self-checking bench for cond_exec_unit: directed cases plus randomized traffic
// compared against a behavioural flags/condition model.
module tb_cond_exec_unit;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;

    int unsigned n_checks;
    int unsigned n_errors;

    logic [3:0] mflags;
    bit         mvalid;

    cond_exec_unit #(.FLAG_RST(4'b0000)) dut (
        .clk(clk), .reset(reset), .en(en), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .CondEx(CondEx), .Flags(Flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Conditions come in complementary pairs: even code tests a predicate, odd code its inverse.
    function automatic bit ref_cond(input logic [3:0] cc, input logic [3:0] f);
        bit fn, fz, fc, fv, base;
        fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
        case (cc[3:1])
            3'd0: base = fz;
            3'd1: base = fc;
            3'd2: base = fn;
            3'd3: base = fv;
            3'd4: base = fc && !fz;
            3'd5: base = (fn == fv);
            3'd6: base = !fz && (fn == fv);
            default: base = 1'b1;
        endcase
        if (cc == 4'hF) return 1'b0;
        return cc[0] ? !base : base;
    endfunction

    // One instruction: drive, check combinational outputs, clock, check new flags.
    task automatic apply(input bit r, input bit e, input logic [3:0] cc, input logic [3:0] alu,
                         input logic [1:0] fw, input bit pcs, input bit rw, input bit mw,
                         input bit nw);
        bit pass, g;
        reset = r; en = e; Cond = cc; ALUFlags = alu; FlagW = fw;
        PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
        #1;
        pass = mvalid ? ref_cond(cc, mflags) : 1'b0;
        g = pass && e && !r;
        if (mvalid) check_eq("condex", {31'd0, CondEx}, {31'd0, pass});
        check_eq("pcsrc", {31'd0, PCSrc}, {31'd0, g && pcs});
        check_eq("regwrite", {31'd0, RegWrite}, {31'd0, g && rw && !nw});
        check_eq("memwrite", {31'd0, MemWrite}, {31'd0, g && mw});
        if (r) begin
            mflags = 4'b0000;
            mvalid = 1'b1;
        end else if (g) begin
            if (fw[1]) mflags[3:2] = alu[3:2];
            if (fw[0]) mflags[1:0] = alu[1:0];
        end
        @(posedge clk);
        #1;
        if (mvalid) check_eq("flags", {28'd0, Flags}, {28'd0, mflags});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        mvalid = 1'b0;
        mflags = 4'b0000;

        // 1: reset forces strobes low even with everything requested
        apply(1, 1, 4'hE, 4'hF, 2'b11, 1, 1, 1, 0);
        check_eq("t1_flags", {28'd0, Flags}, 32'h0);

        // 2: compare-class op writes flags but not Rd; EQ then sees Z
        apply(0, 1, 4'hE, 4'b0100, 2'b11, 0, 1, 0, 1);
        check_eq("t2_flags", {28'd0, Flags}, 32'h4);
        apply(0, 1, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0);

        // 3: only N,Z half updated
        apply(0, 1, 4'hE, 4'b1011, 2'b10, 0, 0, 0, 0);
        check_eq("t3_flags", {28'd0, Flags}, 32'h8);

        // 4: failed condition suppresses strobes and flag writes
        apply(1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        apply(0, 1, 4'h0, 4'hF, 2'b11, 0, 1, 1, 0);
        check_eq("t4_flags", {28'd0, Flags}, 32'h0);

        // 5: signed comparisons with N=1,V=1
        apply(0, 1, 4'hE, 4'b1001, 2'b11, 0, 0, 0, 0);
        apply(0, 1, 4'hA, 4'h0, 2'b00, 0, 0, 0, 0);
        apply(0, 1, 4'hB, 4'h0, 2'b00, 0, 0, 0, 0);
        apply(0, 1, 4'hC, 4'h0, 2'b00, 0, 0, 0, 0);
        apply(0, 1, 4'hF, 4'h0, 2'b00, 0, 0, 0, 0);
        check_eq("t5_flags", {28'd0, Flags}, 32'h9);

        // 6: stall holds flags, release commits
        apply(0, 0, 4'hE, 4'b0110, 2'b11, 0, 1, 0, 0);
        check_eq("t6_stall_flags", {28'd0, Flags}, 32'h9);
        apply(0, 1, 4'hE, 4'b0110, 2'b11, 0, 1, 0, 0);
        check_eq("t6_flags", {28'd0, Flags}, 32'h6);

        // reset during stall wins
        apply(1, 0, 4'hE, 4'hF, 2'b11, 1, 1, 1, 0);
        check_eq("rst_stall_flags", {28'd0, Flags}, 32'h0);

        for (int i = 0; i < 2000; i++) begin
            apply(($urandom_range(31) == 0), ($urandom_range(3) != 0),
                  4'($urandom), 4'($urandom), 2'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
